// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI peripheral endpoint.
//   spi_per_state_t : peripheral FSM state (WAIT_IDLE, IDLE, ACTIVE)
//   SPI_DATA_BITS   : default frame width
//   SPI_CPOL/CPHA   : the only supported mode (mode 0)
package spi_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    ACTIVE
  } spi_per_state_t;

  localparam int SPI_DATA_BITS = 8;

  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-FF synchronizer followed by a registered rise/fall detector.
//   clk, rst : system clock, synchronous active-high reset
//   din      : asynchronous input pin
//   level    : synchronized level
//   rise     : one-cycle pulse, registered, after a synchronized 0->1 change
//   fall     : one-cycle pulse, registered, after a synchronized 1->0 change
// A pin change becomes visible on rise/fall after three clk edges.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_p0;
  logic sync_p1;
  logic last_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
      last_p2 <= RST_VAL;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      // stage 0/1: metastability filter
      meta_p0 <= din;
      sync_p1 <= meta_p0;
      // stage 2: edge register
      last_p2 <= sync_p1;
      rise    <= sync_p1 & ~last_p2;
      fall    <= ~sync_p1 & last_p2;
    end
  end

  assign level = sync_p1;

endmodule

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI mode-0, MSB-first peripheral (slave) endpoint.
//   clk, rst    : system clock (>= 8x SCK), synchronous active-high reset
//   SCK, SS     : SPI clock and active-low select, asynchronous
//   MOSI, MISO  : serial data in / out (MISO held 0 while select is high)
//   data_in     : TX byte, written with load while ready_out=1
//   ready_out   : one-entry TX buffer is empty
//   data_out    : last completed RX byte, valid_out pulses when it updates
//   tx_underrun : pulse when a byte starts with no buffered TX data
//   frame_err   : pulse when select rises in the middle of a byte
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int                   DATA_BITS  = SPI_DATA_BITS,
  parameter logic [DATA_BITS-1:0] DEFAULT_TX = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SCK,
  input  logic                 SS,
  input  logic                 MOSI,
  output logic                 MISO,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 load,
  output logic                 ready_out,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 tx_underrun,
  output logic                 frame_err
);

  localparam int             CW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0]  LAST_BIT = CW'(DATA_BITS - 1);

  logic sck_level, sck_rise, sck_fall;
  logic ss_level, ss_rise, ss_fall;
  logic mosi_meta_p0, mosi_sync_p1;

  spi_per_state_t       state;
  logic [1:0]           settle_cnt;
  logic [DATA_BITS-1:0] tx_buf;
  logic [DATA_BITS-1:0] tx_shift;
  logic [DATA_BITS-1:0] rx_shift;
  logic [DATA_BITS-1:0] rx_next;
  logic [DATA_BITS-1:0] cap_data;
  logic [CW-1:0]        bit_cnt;
  logic                 reload_pend;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sck (
    .clk  (clk),
    .rst  (rst),
    .din  (SCK),
    .level(sck_level),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss (
    .clk  (clk),
    .rst  (rst),
    .din  (SS),
    .level(ss_level),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  // stage 0/1: MOSI synchronizer (no edge detection needed)
  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_meta_p0 <= 1'b0;
      mosi_sync_p1 <= 1'b0;
    end else begin
      mosi_meta_p0 <= MOSI;
      mosi_sync_p1 <= mosi_meta_p0;
    end
  end

  // Capture source uses the buffer state before any same-cycle load.
  assign cap_data = ready_out ? DEFAULT_TX : tx_buf;
  assign rx_next  = {rx_shift[DATA_BITS-2:0], mosi_sync_p1};

  // stage 3: protocol FSM acting on the registered edge pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_IDLE;
      settle_cnt  <= 2'd0;
      ready_out   <= 1'b1;
      valid_out   <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
      MISO        <= 1'b0;
      data_out    <= '0;
      bit_cnt     <= '0;
      reload_pend <= 1'b0;
    end else begin
      valid_out   <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;

      case (state)
        WAIT_IDLE: begin
          // The SS synchronizer resets to 1, so its level is only trusted
          // once the reset value has been flushed out of the pipeline.
          MISO <= 1'b0;
          if (settle_cnt != 2'd3) begin
            settle_cnt <= settle_cnt + 2'd1;
          end else if (ss_level && (sck_level == SPI_CPOL)) begin
            state <= IDLE;
          end
        end

        IDLE: begin
          MISO <= 1'b0;
          if (ss_fall) begin
            state       <= ACTIVE;
            tx_shift    <= cap_data;
            MISO        <= cap_data[DATA_BITS-1];
            tx_underrun <= ready_out;
            ready_out   <= 1'b1;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
          end
        end

        ACTIVE: begin
          if (ss_rise) begin
            state       <= IDLE;
            MISO        <= 1'b0;
            frame_err   <= (bit_cnt != '0);
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
          end else if (sck_rise) begin
            rx_shift <= rx_next;
            if (bit_cnt == LAST_BIT) begin
              data_out    <= rx_next;
              valid_out   <= 1'b1;
              bit_cnt     <= '0;
              reload_pend <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sck_fall) begin
            // First fall after a completed byte starts the next TX byte,
            // allowing back-to-back bytes under one select.
            if (reload_pend) begin
              tx_shift    <= cap_data;
              MISO        <= cap_data[DATA_BITS-1];
              tx_underrun <= ready_out;
              ready_out   <= 1'b1;
              reload_pend <= 1'b0;
            end else begin
              tx_shift <= {tx_shift[DATA_BITS-2:0], 1'b0};
              MISO     <= tx_shift[DATA_BITS-2];
            end
          end
        end

        default: state <= WAIT_IDLE;
      endcase

      // Host write wins over a same-cycle capture: the byte stays buffered.
      if (load && ready_out) begin
        tx_buf    <= data_in;
        ready_out <= 1'b0;
      end
    end
  end

endmodule

// File: doc/spi_peripheral.md
# spi_peripheral

SPI peripheral (slave) endpoint for SPI mode 0 (CPOL=0, CPHA=0), MSB first, and the counterpart of `spi_controller`. It oversamples `SCK`, `SS` and `MOSI` in the system clock domain and shifts a received byte in from `MOSI` while shifting a preloaded byte out on `MISO`. It sits at the device side of an SPI link: the host logic loads a TX byte through a one-entry buffer and collects each RX byte as a one-cycle `valid_out` pulse.

## Interface
- `DATA_BITS`, default 8: frame width in bits.
- `DEFAULT_TX`, default 8'h00: byte shifted out when no TX byte is buffered at frame start.
- `clk` in 1: system clock. Must run at ≥ 8× the `SCK` frequency.
- `rst` in 1: synchronous, active-high reset.
- `SCK` in 1: SPI clock from the controller, asynchronous to `clk`.
- `SS` in 1: active-low slave select, asynchronous.
- `MOSI` in 1: serial data from the controller, asynchronous.
- `MISO` out 1: serial data to the controller. Driven 0 whenever `SS` (synced) is high.
- `data_in` in DATA_BITS: TX byte to load.
- `load` in 1: write strobe for `data_in`. Accepted only while `ready_out`=1.
- `ready_out` out 1: the TX buffer is empty and can accept `load`.
- `data_out` out DATA_BITS: last completed RX byte. Held until the next frame completes.
- `valid_out` out 1: one-cycle pulse when `data_out` updates.
- `tx_underrun` out 1: one-cycle pulse when a frame starts with an empty TX buffer.
- `frame_err` out 1: one-cycle pulse when `SS` deasserts mid-frame.

## Operation
- **Input conditioning.** `SCK`, `SS` and `MOSI` each pass through a 2-FF synchronizer. `SCK` and `SS` feed a registered edge detector. Synchronizer reset values are `SCK`=0, `SS`=1, `MOSI`=0.
- **FSM states.** The FSM has three states: WAIT_IDLE, IDLE and ACTIVE.
  - WAIT_IDLE is the reset state. It moves to IDLE once synced `SS`=1. A select that is already low when reset releases is ignored until `SS` returns high.
  - IDLE moves to ACTIVE on the falling edge of synced `SS` (frame start).
  - ACTIVE moves back to IDLE on the rising edge of synced `SS`.
- **Frame start.**
  - The TX shift register loads from the buffer if it is full, otherwise from `DEFAULT_TX` (and `tx_underrun` pulses).
  - The buffer is marked empty (`ready_out`=1), the bit counter is cleared, and `MISO` is driven with the MSB.
- **Synced `SCK` rising edge (ACTIVE):** RX shift ← {rx[DATA_BITS-2:0], MOSI_sync}; bit counter increments.
- **Bit counter reaching DATA_BITS:**
  - `data_out` ← the assembled byte and `valid_out` pulses. The counter clears.
  - The next `SCK` falling edge reloads the TX shift register from the buffer or `DEFAULT_TX`, exactly as at frame start. This supports back-to-back frames under one `SS` assertion.
- **Synced `SCK` falling edge (ACTIVE, not a reload):** TX shift shifts left and `MISO` ← the new MSB.
- **`SS` rising with counter ≠ 0:** the partial byte is discarded, there is no `valid_out`, and `frame_err` pulses. `SS` rising with counter = 0 is a clean end of frame.
- **TX buffer rules.**
  - `load` while `ready_out`=1 stores `data_in` and clears `ready_out` on the next cycle.
  - `load` while `ready_out`=0 is ignored; the buffer is never overwritten.
- **`load` in the same cycle as a frame-start/reload capture:** the capture uses the pre-write buffer state. The written byte stays buffered for the next frame, and `ready_out` ends at 0.
- **Ignored edges.** `SCK` edges seen in WAIT_IDLE or IDLE are ignored.

## Timing
- **Reset values:** `MISO`=0, `ready_out`=1, `valid_out`=0, `data_out`=0, `tx_underrun`=0, `frame_err`=0, state WAIT_IDLE, buffer empty.
- **Input latency:** a pin edge is acted on 3 `clk` cycles later (2 synchronizer stages plus 1 edge register). `MISO` therefore changes 3–4 cycles after the `SCK` fall or `SS` fall. This is why `SCK` half-period must be ≥ 4 `clk` cycles.
- **Output timing:**
  - `valid_out` asserts on the cycle after the DATA_BITS-th synced rising edge is detected, for exactly 1 cycle.
  - `tx_underrun` and `frame_err` each assert for 1 cycle, on the cycle after the triggering edge.
- **Minimum `SS` high time between frames:** 3 `clk` cycles.

## Structure
- **Package `spi_pkg`:**
  - the state enum `spi_per_state_t` (WAIT_IDLE, IDLE, ACTIVE);
  - the `DATA_BITS` default;
  - the mode constants (CPOL=0, CPHA=0).
- **Sub-module `spi_sync_edge`:** a 2-FF synchronizer plus rise/fall detector, with the reset value as a parameter. It is instantiated for `SCK` and `SS`. `MOSI` uses the synchronizer path only.

## Test plan
- **Basic exchange.** Preload 0xA5, then the controller sends 0xFA. Required: `MISO` sampled on `SCK` rising edges reads 1,0,1,0,0,1,0,1; `data_out`=0xFA with a single `valid_out` pulse; `ready_out` rises at `SS` fall.
- **Back-to-back frames.** Under one `SS` assertion, send 0xFB then 0xFC, reloading 0x3C while `ready_out`=1. Required: two `valid_out` pulses (0xFB, 0xFC); second MISO byte is 0x3C.
- **Underrun.** With `DEFAULT_TX`=0xFF and no load, the controller sends 0xFE. Required: `tx_underrun` pulse at frame start; MISO reads 0xFF; `data_out`=0xFE.
- **Abort and blocked load.**
  - Raise `SS` after 3 `SCK` bits. Required: `frame_err` pulse; no `valid_out`; `data_out` unchanged.
  - Then `load` twice (0x11, 0x22). Required: the next frame sends 0x11.
- **Reset mid-frame.** Assert `rst` for 1 cycle during bit 4 with `SS` held low. Required: all outputs return to their reset values; remaining `SCK` edges are ignored until `SS` goes high. The next full frame (0x5A) completes normally with `data_out`=0x5A.
